// File: rtl/upm_thermal_ctrl_pkg.sv
// Shared types for the UPM thermal chain scan sequencer.
// Defining UPM_THERMAL_CTRL_SO_RETIME_EN adds the DRAIN state and one cycle of overhead.
package upm_thermal_ctrl_pkg;

  localparam int LEN_MAX_W = 9;
  typedef logic [LEN_MAX_W-1:0] upm_thermal_ctrl_len_t;

`ifdef UPM_THERMAL_CTRL_SO_RETIME_EN
  localparam int PHASE_OVERHEAD = 5;
  typedef enum logic [2:0] {
    IDLE, SELECT, CAPTURE, SHIFT, UPDATE, DONE, DRAIN
  } upm_thermal_ctrl_state_e;
`else
  localparam int PHASE_OVERHEAD = 4;
  typedef enum logic [2:0] {
    IDLE, SELECT, CAPTURE, SHIFT, UPDATE, DONE
  } upm_thermal_ctrl_state_e;
`endif

endpackage

// File: rtl/upm_thermal_ctrl_shreg.sv
// Write/read shift registers and bit counter for the thermal chain sequencer.
// si is registered here so it lines up with the registered shift strobe.
module upm_thermal_ctrl_shreg #(
  parameter int DR_WIDTH = 64,
  parameter int LEN_W    = $clog2(DR_WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [LEN_W-1:0]    len,
  input  logic [DR_WIDTH-1:0] wdata,
  input  logic                shift_en,
  input  logic                sample_en,
  input  logic                so_bit,
  output logic                si,
  output logic                last,
  output logic [DR_WIDTH-1:0] rdata
);

  logic [DR_WIDTH-1:0] wreg;
  logic [DR_WIDTH-1:0] smask;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt;

  // cnt counts shift cycles already entered, so it equals len_q during the final one.
  assign last = (cnt == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg  <= '0;
      smask <= '0;
      len_q <= '0;
      cnt   <= '0;
      rdata <= '0;
      si    <= 1'b0;
    end else if (load) begin
      wreg  <= wdata;
      smask <= DR_WIDTH'(1);
      len_q <= len;
      cnt   <= '0;
      rdata <= '0;
      si    <= 1'b0;
    end else begin
      si <= shift_en ? wreg[0] : 1'b0;
      if (shift_en) begin
        wreg <= wreg >> 1;
        cnt  <= cnt + LEN_W'(1);
      end
      // One-hot mask walks up so each sample lands in the next rdata bit.
      if (sample_en) begin
        rdata <= rdata | (smask & {DR_WIDTH{so_bit}});
        smask <= smask << 1;
      end
    end
  end

endmodule

// File: rtl/upm_thermal_chain_ctrl.sv
// Host-side scan sequencer for the UPM thermal CBB daisy chain.
// UPM_THERMAL_CTRL_SO_RETIME_EN retimes so through one flop and inserts a DRAIN cycle.
module upm_thermal_chain_ctrl
  import upm_thermal_ctrl_pkg::*;
#(
  parameter int DR_WIDTH = 64,
  parameter int LEN_W    = $clog2(DR_WIDTH + 1)
) (
  input  logic                tck,
  input  logic                fdfx_powergood,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DR_WIDTH-1:0] req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DR_WIDTH-1:0] rsp_rdata,
  input  logic                power_enable_error,
  output logic                sel,
  output logic                capture,
  output logic                shift,
  output logic                update,
  output logic                si,
  input  logic                so
);

  upm_thermal_ctrl_state_e state, nxt;
  logic nxt_err;
  logic load;
  logic len_bad;
  logic last;
  logic so_bit;
  logic samp_ok;
  logic sample_en;

  assign load    = (state == IDLE) && req_valid;
  assign len_bad = upm_thermal_ctrl_len_t'(req_len) > upm_thermal_ctrl_len_t'(DR_WIDTH);
  // A bit whose shift cycle saw a power fault is never collected.
  assign samp_ok = shift & ~power_enable_error;

`ifdef UPM_THERMAL_CTRL_SO_RETIME_EN
  logic so_q;
  logic samp_d;

  always_ff @(posedge tck or negedge fdfx_powergood) begin
    if (!fdfx_powergood) begin
      so_q   <= 1'b0;
      samp_d <= 1'b0;
    end else begin
      so_q   <= so;
      samp_d <= samp_ok;
    end
  end

  assign so_bit    = so_q;
  assign sample_en = samp_d;
`else
  assign so_bit    = so;
  assign sample_en = samp_ok;
`endif

  always_comb begin
    nxt     = state;
    nxt_err = 1'b0;
    case (state)
      IDLE:    if (req_valid) begin
                 if (len_bad) begin
                   nxt     = DONE;
                   nxt_err = 1'b1;
                 end else begin
                   nxt = SELECT;
                 end
               end
      SELECT:  nxt = CAPTURE;
      CAPTURE: nxt = last ? UPDATE : SHIFT;
`ifdef UPM_THERMAL_CTRL_SO_RETIME_EN
      SHIFT:   nxt = last ? DRAIN : SHIFT;
      DRAIN:   nxt = UPDATE;
`else
      SHIFT:   nxt = last ? UPDATE : SHIFT;
`endif
      UPDATE:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (power_enable_error && (state == SELECT || state == CAPTURE || state == SHIFT)) begin
      nxt     = DONE;
      nxt_err = 1'b1;
    end
  end

  // Strobes are decoded from the next state so every output comes straight off a flop.
  always_ff @(posedge tck or negedge fdfx_powergood) begin
    if (!fdfx_powergood) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      sel       <= 1'b0;
      capture   <= 1'b0;
      shift     <= 1'b0;
      update    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= nxt;
      req_ready <= (nxt == IDLE);
      sel       <= (nxt != IDLE) && (nxt != DONE);
      capture   <= (nxt == CAPTURE);
      shift     <= (nxt == SHIFT);
      update    <= (nxt == UPDATE);
      rsp_valid <= (nxt == DONE);
      rsp_err   <= nxt_err;
    end
  end

  upm_thermal_ctrl_shreg #(
    .DR_WIDTH (DR_WIDTH),
    .LEN_W    (LEN_W)
  ) u_shreg (
    .clk       (tck),
    .rst_n     (fdfx_powergood),
    .load      (load),
    .len       (req_len),
    .wdata     (req_wdata),
    .shift_en  (nxt == SHIFT),
    .sample_en (sample_en),
    .so_bit    (so_bit),
    .si        (si),
    .last      (last),
    .rdata     (rsp_rdata)
  );

endmodule

// File: tb/tb_upm_thermal_chain_ctrl.sv
// Directed bench for upm_thermal_chain_ctrl against an 8-bit chain register model.
module tb_upm_thermal_chain_ctrl;

  localparam int DW = 64;
  localparam int LW = $clog2(DW + 1);
`ifdef UPM_THERMAL_CTRL_SO_RETIME_EN
  localparam int OVH = 5;
`else
  localparam int OVH = 4;
`endif

  logic          tck = 1'b0;
  logic          fdfx_powergood = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          power_enable_error = 1'b0;
  logic          sel, capture, shift, update, si;
  logic          so;

  int n_chk = 0;
  int n_err = 0;

  upm_thermal_chain_ctrl #(.DR_WIDTH(DW)) dut (
    .tck                (tck),
    .fdfx_powergood     (fdfx_powergood),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_len            (req_len),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_err            (rsp_err),
    .rsp_rdata          (rsp_rdata),
    .power_enable_error (power_enable_error),
    .sel                (sel),
    .capture            (capture),
    .shift              (shift),
    .update             (update),
    .si                 (si),
    .so                 (so)
  );

  always #5 tck = ~tck;

  // 8-bit chain register: capture loads the shadow, shift moves toward so, update commits.
  logic [7:0] hreg, sr;
  always @(posedge tck or negedge fdfx_powergood) begin
    if (!fdfx_powergood) begin
      hreg <= 8'h3C;
      sr   <= 8'h00;
    end else if (capture) sr <= hreg;
    else if (shift)       sr <= {si, sr[7:1]};
    else if (update)      hreg <= sr;
  end
  assign so = sr[0];

  int sel_n = 0, cap_n = 0, sh_n = 0, upd_n = 0, rv_n = 0, si_bad = 0, multi_n = 0;
  logic [1023:0] si_log = '0;
  always @(negedge tck) begin
    if (sel)       sel_n++;
    if (capture)   cap_n++;
    if (update)    upd_n++;
    if (rsp_valid) rv_n++;
    if (!shift && si) si_bad++;
    if (int'(capture) + int'(shift) + int'(update) > 1) multi_n++;
    if (shift) begin
      si_log[sh_n[9:0]] = si;
      sh_n++;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] si_word(input int s0, input int len);
    logic [DW-1:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < len; k++) begin
      idx = s0 + k;
      w[k] = si_log[idx[9:0]];
    end
    return w;
  endfunction

  task automatic do_req(input int len, input logic [DW-1:0] wd, input int perr_at,
                        output int lat, output logic [DW-1:0] rd, output logic er);
    int sc;
    @(negedge tck);
    req_valid = 1'b1;
    req_len   = LW'(len);
    req_wdata = wd;
    @(posedge tck);
    #1 req_valid = 1'b0;
    lat = 0; sc = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge tck);
      if (shift) begin
        if (sc == perr_at) power_enable_error = 1'b1;
        sc++;
      end
      if (rsp_valid) begin
        lat = n; rd = rsp_rdata; er = rsp_err;
        break;
      end
    end
    power_enable_error = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s0, a0, c0, u0, sl0, rv0, sc, r1, r2, acc2;
    logic [DW-1:0] rd, d1, d2;
    logic er, ok;

    // Reset state
    repeat (3) @(posedge tck);
    @(negedge tck);
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {sel, capture, shift, update, si}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    fdfx_powergood = 1'b1;
    repeat (2) @(negedge tck);

    // len=8, wdata=A5 against chain holding 3C
    s0 = sh_n; a0 = cap_n; u0 = upd_n;
    do_req(8, 64'hA5, -1, lat, rd, er);
    chk("len8_latency", lat, 8 + OVH);
    chk("len8_rdata", rd, 64'h3C);
    chk("len8_err", er, 0);
    chk("len8_si_seq", si_word(s0, 8), 64'hA5);
    chk("len8_shift_cycles", sh_n - s0, 8);
    chk("len8_capture", cap_n - a0, 1);
    chk("len8_update", upd_n - u0, 1);
    chk("len8_chain_reg", hreg, 8'hA5);
    @(negedge tck);
    chk("len8_ready_after", req_ready, 1);

    // len=0
    s0 = sh_n; a0 = cap_n; u0 = upd_n; sl0 = sel_n;
    do_req(0, 64'hFF, -1, lat, rd, er);
    chk("len0_latency", lat, 4);
    chk("len0_rdata", rd, 0);
    chk("len0_err", er, 0);
    chk("len0_shift", sh_n - s0, 0);
    chk("len0_capture", cap_n - a0, 1);
    chk("len0_update", upd_n - u0, 1);
    chk("len0_sel_cycles", sel_n - sl0, 3);

    // len=DR_WIDTH+1 is rejected without touching the chain
    sl0 = sel_n;
    do_req(DW + 1, 64'h1234, -1, lat, rd, er);
    chk("badlen_latency", lat, 1);
    chk("badlen_err", er, 1);
    chk("badlen_sel", sel_n - sl0, 0);
    chk("badlen_rdata", rd, 0);

    // len=16 with power fault in shift cycle 5; chain holds A5, so bits 0..4 = 5'b00101
    u0 = upd_n;
    do_req(16, 64'hFFFF, 5, lat, rd, er);
    chk("perr_latency", lat, 9);
    chk("perr_err", er, 1);
    chk("perr_rdata", rd, 64'h05);
    chk("perr_no_update", upd_n - u0, 0);
    @(negedge tck);
    chk("perr_strobes_idle", {sel, capture, shift, update}, 0);

    // Reset in shift cycle 3 of a 32-bit access
    @(negedge tck);
    req_valid = 1'b1; req_len = LW'(32); req_wdata = 64'hDEADBEEF;
    @(posedge tck);
    #1 req_valid = 1'b0;
    sc = 0; ok = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge tck);
      if (shift) begin
        if (sc == 3) begin ok = 1'b1; break; end
        sc++;
      end
    end
    chk("abort_reached_shift3", ok, 1);
    rv0 = rv_n; u0 = upd_n;
    #2 fdfx_powergood = 1'b0;
    #1;
    chk("abort_strobes", {sel, capture, shift, update, si}, 0);
    chk("abort_rsp", {rsp_valid, rsp_err}, 0);
    chk("abort_ready", req_ready, 1);
    repeat (2) @(negedge tck);
    fdfx_powergood = 1'b1;
    repeat (40) @(negedge tck);
    chk("abort_no_rsp", rv_n - rv0, 0);
    chk("abort_no_update", upd_n - u0, 0);
    chk("abort_ready_release", req_ready, 1);

    // Back-to-back len=4 with req_valid held; chain holds 3C after reset
    @(negedge tck);
    req_valid = 1'b1; req_len = LW'(4); req_wdata = 64'h9;
    @(posedge tck);
    #1;
    r1 = 0; r2 = 0; acc2 = 0; d1 = '0; d2 = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge tck);
      if (rsp_valid && r1 == 0) begin
        r1 = n; d1 = rsp_rdata; req_wdata = 64'h6;
      end else if (rsp_valid) begin
        r2 = n; d2 = rsp_rdata;
        break;
      end
      if (r1 != 0 && acc2 == 0 && req_ready) begin
        acc2 = n;
        @(posedge tck);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_first_latency", r1, 4 + OVH);
    chk("b2b_second_accept", acc2, 4 + OVH + 1);
    chk("b2b_second_latency", r2 - acc2, 4 + OVH);
    chk("b2b_rdata1", d1, 64'hC);
    chk("b2b_rdata2", d2, 64'h3);
    chk("b2b_chain_reg", hreg, 8'h69);

    chk("si_zero_outside_shift", si_bad, 0);
    chk("one_strobe_at_a_time", multi_n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
